multimode_queue_scheduler: RTL and testbench
============================================

Name: multimode_queue_scheduler

Overview:
- Parametrised successor of the non-AXI domain queueing stage. Sits between the packet ingress and the memory-side consumer.
- Stores packets in NQ per-ID FIFOs and grants exactly one head packet at a time to the consumer.
- The winning FIFO is chosen by a runtime-selectable policy: TDMA, EDF or fixed priority.

Parameters:
NQ, 4, number of queues/IDs (>=2)
W, 128, packet width in bits
DEPTH, 16, entries per queue (power of 2)
TW, 32, width of timestamps, deadlines and periods

Ports:
clock  in  1  single clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
packet  in  W  ingress packet
valid  in  1  ingress packet valid for one cycle
id  in  $clog2(NQ)  target queue for packet
mode  in  2  0=TDMA, 1=EDF, 2=fixed priority, 3=reserved (behaves as 2)
deadlines  in  NQ x TW  relative deadline per queue (EDF)
periods  in  NQ x TW  TDMA slot length / EDF release period per queue
packet_out  out  W  granted head packet, registered
consumed  in  1  consumer pops packet_out
activate_out  out  1  packet_out valid
full  out  NQ  per-queue full flag

Behaviour:
- Reset (reset=0, async): all queues empty, packet_out=0, activate_out=0, full=0, FSM=IDLE, timestamp=0, TDMA owner=0, slot counter=0, EDF release counters=0, abs_deadline[i]=deadlines[i].
- Push: valid=1 and full[id]=0 -> packet written at edge. Push to a full queue is dropped silently, except when the same queue is popped in the same cycle; then it is accepted. full[i] is registered and updates the same edge.
- Arbiter FSM:
  - IDLE: compute winner among eligible non-empty queues. If one exists: latch grant_id, packet_out<=head, activate_out<=1, go to GRANT. A packet pushed at edge t into an empty eligible queue is visible at edge t+1.
  - GRANT: packet_out and grant_id are held stable. consumed=1 pops head of grant_id, sets activate_out<=0, returns to IDLE. Minimum 2 cycles per packet.
  - consumed while activate_out=0 is ignored.
  - The grant is never revoked by a slot or deadline change.
- TDMA (mode 0):
  - Only the owner queue is eligible.
  - The slot counter increments every cycle. When it equals periods[owner]-1, the counter clears and the owner advances (owner+1) mod NQ.
  - periods[i]=0: queue i is skipped, owner advances next cycle.
  - If all periods are 0, nothing is ever granted.
- EDF (mode 1):
  - Free-running timestamp (TW bits, wraps).
  - Per-queue release counter. On reaching periods[i]-1 (or every cycle if periods[i]=0) it clears and sets abs_deadline[i]<=timestamp+deadlines[i] (mod 2^TW).
  - The winner is the non-empty queue with the smallest signed difference (abs_deadline[i]-timestamp), compared as TW-bit signed values so wrap-around is handled.
  - Ties: lowest index wins.
- Fixed priority (modes 2/3): the lowest-index non-empty queue wins.
- Mode change:
  - Takes effect at the next IDLE evaluation; a GRANT in progress completes.
  - TDMA and EDF counters keep running in all modes.
- Pointers wrap modulo DEPTH. Occupancy counter is $clog2(DEPTH)+1 bits.

Optional Feature:
- Macro: MMQS_DROP_STATS_EN.
- Defined: adds output drop_count (NQ x 16). Per queue, a 16-bit counter increments on each dropped push and saturates at 16'hFFFF. It is cleared only by reset.
- Undefined: no port and no logic. Drops remain silent.

Test Plan:
- Mode 2, push 0x..01 to id 2, then 0x..02 to id 0 -> first grant is 0x..01 (queue 0 was empty at that evaluation). After consumed, grant is 0x..02. activate_out low one cycle between grants.
- Mode 2, push 17 packets 0x..10..0x..20 to id 0 with DEPTH=16, no consume -> full[0]=1 after the 16th push; 0x..20 is dropped (drop_count[0]=1 if MMQS_DROP_STATS_EN). 16 consumes return 0x..10..0x..1F in order, then activate_out stays 0.
- Mode 0, periods={4,0,4,4}, one packet in each of queues 1 and 3 -> queue 1 is never granted; queue 3 is granted only while owner=3. activate_out never rises for queue 1.
- Mode 1, deadlines={100,20,50,80}, periods all 0x100, one packet in each queue -> grant order is queue 1, 2, 3, 0.
- Mode 1, timestamp forced near wrap: abs_deadline[0]=0xFFFFFFF0, abs_deadline[1]=0x00000010 at timestamp 0xFFFFFFE0 -> queue 0 is granted first.
- Reset pulse (reset=0) while in GRANT with 3 packets queued -> activate_out=0 and packet_out=0 immediately. After release, no grant occurs until a new push.

Source files
------------

// File: rtl/multimode_queue_scheduler.sv
// Per-ID packet FIFOs feeding a single-grant arbiter with runtime-selectable TDMA, EDF or fixed
// priority policy. Define MMQS_DROP_STATS_EN to add saturating per-queue drop counters.
module multimode_queue_scheduler #(
   parameter int unsigned NQ    = 4,
   parameter int unsigned W     = 128,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned TW    = 32
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [W-1:0]              packet,
   input  logic                      valid,
   input  logic [$clog2(NQ)-1:0]     id,
   input  logic [1:0]                mode,
   input  logic [NQ-1:0][TW-1:0]     deadlines,
   input  logic [NQ-1:0][TW-1:0]     periods,
   output logic [W-1:0]              packet_out,
   input  logic                      consumed,
   output logic                      activate_out,
   output logic [NQ-1:0]             full
`ifdef MMQS_DROP_STATS_EN
   ,
   output logic [NQ-1:0][15:0]       drop_count
`endif
);

   localparam int unsigned IW = $clog2(NQ);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic {StIdle, StGrant} state_e;
   state_e state_q, state_d;

   logic [W-1:0]              mem [NQ][DEPTH];
   logic [NQ-1:0][PW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [NQ-1:0][CW-1:0]     count_q, count_d;
   logic [NQ-1:0]             push_vec, pop_vec, full_d;
   logic                      pop, push_ok;

   logic [IW-1:0]             grant_id_q, grant_id_d, owner_q, owner_d, win_id;
   logic                      win_valid, activate_d;
   logic [W-1:0]              packet_out_d;
   logic [TW-1:0]             ts_q, slot_q, slot_d, best_slack;
   logic [NQ-1:0][TW-1:0]     rel_q, rel_d, abs_q, abs_d, slack;

   // A full queue still accepts a push when its head leaves on the same edge.
   assign pop     = (state_q == StGrant) && consumed;
   assign push_ok = valid && (!full[id] || (pop && (grant_id_q == id)));

   always_comb begin
      for (int i = 0; i < NQ; i++) begin
         push_vec[i] = push_ok && (id == IW'(i));
         pop_vec[i]  = pop && (grant_id_q == IW'(i));
         count_d[i]  = count_q[i] + CW'(push_vec[i]) - CW'(pop_vec[i]);
         full_d[i]   = (count_d[i] == CW'(DEPTH));
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem[id][wr_ptr_q[id]] <= packet;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full     <= '0;
      end else begin
         for (int i = 0; i < NQ; i++) begin
            if (push_vec[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
            if (pop_vec[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
         end
         count_q <= count_d;
         full    <= full_d;
      end
   end

   // Time base: TDMA slot/owner and EDF release counters run regardless of the active mode.
   always_comb begin
      slot_d  = slot_q + TW'(1);
      owner_d = owner_q;
      if ((periods[owner_q] == '0) || (slot_q == periods[owner_q] - TW'(1))) begin
         slot_d  = '0;
         owner_d = (owner_q == IW'(NQ - 1)) ? '0 : owner_q + IW'(1);
      end
      for (int i = 0; i < NQ; i++) begin
         rel_d[i] = rel_q[i] + TW'(1);
         abs_d[i] = abs_q[i];
         if ((periods[i] == '0) || (rel_q[i] == periods[i] - TW'(1))) begin
            rel_d[i] = '0;
            abs_d[i] = ts_q + deadlines[i];
         end
         slack[i] = abs_q[i] - ts_q;
      end
   end

   always_comb begin
      win_valid  = 1'b0;
      win_id     = '0;
      best_slack = '0;
      case (mode)
         2'd0: begin
            if ((count_q[owner_q] != '0) && (periods[owner_q] != '0)) begin
               win_valid = 1'b1;
               win_id    = owner_q;
            end
         end
         2'd1: begin
            // Signed slack keeps the ordering correct across timestamp wrap; ties keep lowest index.
            for (int i = 0; i < NQ; i++) begin
               if ((count_q[i] != '0) &&
                   (!win_valid || ($signed(slack[i]) < $signed(best_slack)))) begin
                  win_valid  = 1'b1;
                  win_id     = IW'(i);
                  best_slack = slack[i];
               end
            end
         end
         default: begin
            for (int i = NQ - 1; i >= 0; i--) begin
               if (count_q[i] != '0) begin
                  win_valid = 1'b1;
                  win_id    = IW'(i);
               end
            end
         end
      endcase
   end

   always_comb begin
      state_d      = state_q;
      grant_id_d   = grant_id_q;
      packet_out_d = packet_out;
      activate_d   = activate_out;
      case (state_q)
         StIdle: begin
            if (win_valid) begin
               grant_id_d   = win_id;
               packet_out_d = mem[win_id][rd_ptr_q[win_id]];
               activate_d   = 1'b1;
               state_d      = StGrant;
            end
         end
         StGrant: begin
            if (consumed) begin
               activate_d = 1'b0;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         grant_id_q   <= '0;
         packet_out   <= '0;
         activate_out <= 1'b0;
         ts_q         <= '0;
         slot_q       <= '0;
         owner_q      <= '0;
         rel_q        <= '0;
         abs_q        <= deadlines;
      end else begin
         state_q      <= state_d;
         grant_id_q   <= grant_id_d;
         packet_out   <= packet_out_d;
         activate_out <= activate_d;
         ts_q         <= ts_q + TW'(1);
         slot_q       <= slot_d;
         owner_q      <= owner_d;
         rel_q        <= rel_d;
         abs_q        <= abs_d;
      end
   end

`ifdef MMQS_DROP_STATS_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         drop_count <= '0;
      end else if (valid && !push_ok && (drop_count[id] != 16'hFFFF)) begin
         drop_count[id] <= drop_count[id] + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_multimode_queue_scheduler.sv
// Self-checking bench for multimode_queue_scheduler: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_multimode_queue_scheduler;

   localparam int NQ = 4;
   localparam int W = 128;
   localparam int DEPTH = 16;
   localparam int TW = 32;

   logic                  clock = 1'b0;
   logic                  reset;
   logic [W-1:0]          packet;
   logic                  valid;
   logic [1:0]            id;
   logic [1:0]            mode;
   logic [NQ-1:0][TW-1:0] deadlines;
   logic [NQ-1:0][TW-1:0] periods;
   logic [W-1:0]          packet_out;
   logic                  consumed;
   logic                  activate_out;
   logic [NQ-1:0]         full;
`ifdef MMQS_DROP_STATS_EN
   logic [NQ-1:0][15:0]   drop_count;
`endif

   multimode_queue_scheduler #(.NQ(NQ), .W(W), .DEPTH(DEPTH), .TW(TW)) dut (
      .clock(clock),
      .reset(reset),
      .packet(packet),
      .valid(valid),
      .id(id),
      .mode(mode),
      .deadlines(deadlines),
      .periods(periods),
      .packet_out(packet_out),
      .consumed(consumed),
      .activate_out(activate_out),
      .full(full)
`ifdef MMQS_DROP_STATS_EN
      ,
      .drop_count(drop_count)
`endif
   );

   always #5 clock = ~clock;

   // Reference model state
   logic [W-1:0]  mq [NQ][$];
   bit            m_act;
   logic [W-1:0]  m_pkt;
   int            m_gid;
   int            m_owner;
   logic [TW-1:0] m_ts, m_slot;
   logic [TW-1:0] m_rel [NQ];
   logic [TW-1:0] m_abs [NQ];
   int            m_drop [NQ];

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   task automatic model_reset();
      for (int i = 0; i < NQ; i++) begin
         mq[i].delete();
         m_rel[i]  = '0;
         m_abs[i]  = deadlines[i];
         m_drop[i] = 0;
      end
      m_act = 0; m_pkt = '0; m_gid = 0; m_owner = 0; m_ts = '0; m_slot = '0;
   endtask

   task automatic model_step();
      bit pop, accept, wv;
      int w;
      logic signed [TW-1:0] s, best;
      pop = m_act && consumed;
      wv = 0; w = 0; best = '0;
      if (!m_act) begin
         if (mode == 2'd0) begin
            if (mq[m_owner].size() != 0 && periods[m_owner] != '0) begin wv = 1; w = m_owner; end
         end else if (mode == 2'd1) begin
            for (int i = 0; i < NQ; i++) begin
               if (mq[i].size() != 0) begin
                  s = m_abs[i] - m_ts;
                  if (!wv || s < best) begin wv = 1; w = i; best = s; end
               end
            end
         end else begin
            for (int i = 0; i < NQ; i++)
               if (!wv && mq[i].size() != 0) begin wv = 1; w = i; end
         end
      end
      accept = valid && (mq[int'(id)].size() < DEPTH || (pop && m_gid == int'(id)));
      if (pop) begin
         void'(mq[m_gid].pop_front());
         m_act = 0;
      end else if (wv) begin
         m_act = 1; m_gid = w; m_pkt = mq[w][0];
      end
      if (accept) mq[int'(id)].push_back(packet);
      else if (valid && m_drop[int'(id)] < 65535) m_drop[int'(id)]++;
      for (int i = 0; i < NQ; i++) begin
         if (periods[i] == '0 || m_rel[i] == periods[i] - 32'd1) begin
            m_rel[i] = '0;
            m_abs[i] = m_ts + deadlines[i];
         end else m_rel[i] = m_rel[i] + 32'd1;
      end
      if (periods[m_owner] == '0 || m_slot == periods[m_owner] - 32'd1) begin
         m_slot = '0;
         m_owner = (m_owner + 1) % NQ;
      end else m_slot = m_slot + 32'd1;
      m_ts = m_ts + 32'd1;
   endtask

   task automatic step();
      model_step();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic enter_reset();
      reset = 1'b0;
      #2;
   endtask

   task automatic release_reset();
      model_reset();
      @(posedge clock);
      #1;
      reset = 1'b1;
      cyc = 0;
   endtask

   task automatic wait_grant(output bit ok);
      ok = activate_out;
      for (int t = 0; t < 8 && !ok; t++) begin
         step();
         ok = activate_out;
      end
   endtask

   task automatic test_reset();
      enter_reset();
      n_vec++;
      if (activate_out !== 1'b0) begin n_err++; $display("FAIL reset_act got %b exp 0", activate_out); end
      n_vec++;
      if (packet_out !== '0) begin n_err++; $display("FAIL reset_pkt got %h exp 0", packet_out); end
      n_vec++;
      if (full !== '0) begin n_err++; $display("FAIL reset_full got %b exp 0", full); end
      release_reset();
      step();
      n_vec++;
      if (activate_out !== 1'b0) begin n_err++; $display("FAIL idle_act got %b exp 0", activate_out); end
   endtask

   task automatic test_fixed_priority();
      mode = 2'd2;
      enter_reset(); release_reset();
      valid = 1; id = 2; packet = 128'h01; step();
      id = 0; packet = 128'h02; step();
      valid = 0;
      n_vec++;
      if (activate_out !== 1'b1 || packet_out !== 128'h01) begin
         n_err++; $display("FAIL fp_first got %b/%h exp 1/01", activate_out, packet_out);
      end
      consumed = 1; step(); consumed = 0;
      n_vec++;
      if (activate_out !== 1'b0) begin n_err++; $display("FAIL fp_gap got %b exp 0", activate_out); end
      step();
      n_vec++;
      if (activate_out !== 1'b1 || packet_out !== 128'h02) begin
         n_err++; $display("FAIL fp_second got %b/%h exp 1/02", activate_out, packet_out);
      end
      consumed = 1; step(); consumed = 0; step();
      n_vec++;
      if (activate_out !== 1'b0) begin n_err++; $display("FAIL fp_empty got %b exp 0", activate_out); end
   endtask

   task automatic test_full_drop();
      bit ok;
      logic [W-1:0] exp;
      mode = 2'd2;
      enter_reset(); release_reset();
      valid = 1; id = 0;
      for (int k = 0; k < 17; k++) begin
         packet = 128'h10 + 128'(k);
         step();
         if (k == 14) begin
            n_vec++;
            if (full[0] !== 1'b0) begin n_err++; $display("FAIL full_early got %b exp 0", full[0]); end
         end
         if (k == 15) begin
            n_vec++;
            if (full[0] !== 1'b1) begin n_err++; $display("FAIL full_set got %b exp 1", full[0]); end
         end
      end
      valid = 0;
`ifdef MMQS_DROP_STATS_EN
      n_vec++;
      if (drop_count[0] !== 16'd1) begin n_err++; $display("FAIL drop_cnt got %0d exp 1", drop_count[0]); end
`endif
      n_vec++;
      if (activate_out !== 1'b1 || packet_out !== 128'h10) begin
         n_err++; $display("FAIL full_head got %b/%h exp 1/10", activate_out, packet_out);
      end
      // Push into the full queue on the same edge its head is consumed.
      valid = 1; packet = 128'h21; consumed = 1; step();
      valid = 0; consumed = 0;
      n_vec++;
      if (full[0] !== 1'b1) begin n_err++; $display("FAIL full_swap got %b exp 1", full[0]); end
      for (int k = 1; k <= 16; k++) begin
         exp = (k < 16) ? 128'h10 + 128'(k) : 128'h21;
         wait_grant(ok);
         n_vec++;
         if (!ok || packet_out !== exp) begin
            n_err++; $display("FAIL full_order got %b/%h exp 1/%h", ok, packet_out, exp);
         end
         consumed = 1; step(); consumed = 0;
      end
      for (int k = 0; k < 5; k++) begin
         step();
         n_vec++;
         if (activate_out !== 1'b0) begin n_err++; $display("FAIL drained_act got %b exp 0", activate_out); end
      end
   endtask

   task automatic test_tdma();
      bit prev;
      int g1, g3;
      g1 = 0; g3 = 0;
      periods[0] = 32'd4; periods[1] = 32'd0; periods[2] = 32'd4; periods[3] = 32'd4;
      mode = 2'd0;
      enter_reset(); release_reset();
      valid = 1; id = 1; packet = 128'hA1; step();
      id = 3; packet = 128'hA3; step();
      valid = 0;
      for (int c = 0; c < 60; c++) begin
         prev = activate_out;
         consumed = activate_out;
         step();
         n_vec++;
         if (activate_out !== m_act) begin n_err++; $display("FAIL tdma_act got %b exp %b", activate_out, m_act); end
         if (activate_out && !prev) begin
            if (packet_out === 128'hA1) g1++;
            if (packet_out === 128'hA3) g3++;
            // Owner sequence repeats every 13 cycles: 0 x4, 1 skipped x1, 2 x4, 3 x4.
            n_vec++;
            if (packet_out !== 128'hA3 || ((cyc - 1) % 13) < 9) begin
               n_err++; $display("FAIL tdma_owner got %h at %0d exp A3 in owner-3 slot", packet_out, cyc);
            end
         end
      end
      consumed = 0;
      n_vec++;
      if (g1 != 0 || g3 != 1) begin n_err++; $display("FAIL tdma_count got q1=%0d q3=%0d exp 0/1", g1, g3); end
   endtask

   task automatic test_edf_order();
      bit ok;
      int order [4] = '{1, 2, 3, 0};
      deadlines[0] = 32'd100; deadlines[1] = 32'd20; deadlines[2] = 32'd50; deadlines[3] = 32'd80;
      for (int i = 0; i < NQ; i++) periods[i] = 32'h100;
      mode = 2'd0;
      enter_reset(); release_reset();
      valid = 1;
      for (int q = 1; q < NQ; q++) begin id = 2'(q); packet = 128'hB0 + 128'(q); step(); end
      id = 0; packet = 128'hB0; mode = 2'd1; step();
      valid = 0;
      for (int j = 0; j < 4; j++) begin
         wait_grant(ok);
         n_vec++;
         if (!ok || packet_out !== 128'hB0 + 128'(order[j])) begin
            n_err++; $display("FAIL edf_order got %b/%h exp 1/%h", ok, packet_out, 128'hB0 + 128'(order[j]));
         end
         consumed = 1; step(); consumed = 0;
      end
   endtask

   task automatic test_edf_signed();
      bit ok;
      deadlines[0] = 32'h0000_0010; deadlines[1] = 32'hFFFF_FFF0;
      deadlines[2] = 32'd5; deadlines[3] = 32'd5;
      for (int i = 0; i < NQ; i++) periods[i] = 32'h100;
      mode = 2'd1;
      enter_reset(); release_reset();
      valid = 1; id = 2; packet = 128'hD2; step();
      id = 0; packet = 128'hD0; step();
      id = 1; packet = 128'hD1; step();
      valid = 0;
      consumed = 1; step(); consumed = 0;
      wait_grant(ok);
      n_vec++;
      if (!ok || packet_out !== 128'hD1) begin n_err++; $display("FAIL edf_wrap got %b/%h exp 1/D1", ok, packet_out); end
      consumed = 1; step(); consumed = 0;
      wait_grant(ok);
      n_vec++;
      if (!ok || packet_out !== 128'hD0) begin n_err++; $display("FAIL edf_wrap2 got %b/%h exp 1/D0", ok, packet_out); end
      consumed = 1; step(); consumed = 0;
   endtask

   task automatic test_reset_in_grant();
      mode = 2'd2;
      enter_reset(); release_reset();
      valid = 1; id = 0;
      for (int k = 0; k < 4; k++) begin packet = 128'hC0 + 128'(k); step(); end
      valid = 0;
      n_vec++;
      if (activate_out !== 1'b1) begin n_err++; $display("FAIL rig_pre got %b exp 1", activate_out); end
      enter_reset();
      n_vec++;
      if (activate_out !== 1'b0 || packet_out !== '0) begin
         n_err++; $display("FAIL rig_async got %b/%h exp 0/0", activate_out, packet_out);
      end
      release_reset();
      for (int k = 0; k < 6; k++) begin
         step();
         n_vec++;
         if (activate_out !== 1'b0 || full !== '0) begin
            n_err++; $display("FAIL rig_idle got %b/%b exp 0/0", activate_out, full);
         end
      end
      valid = 1; id = 3; packet = 128'hCF; step(); valid = 0; step();
      n_vec++;
      if (activate_out !== 1'b1 || packet_out !== 128'hCF) begin
         n_err++; $display("FAIL rig_new got %b/%h exp 1/CF", activate_out, packet_out);
      end
      consumed = 1; step(); consumed = 0;
   endtask

   task automatic test_random();
      for (int i = 0; i < NQ; i++) begin
         periods[i]   = 32'($urandom_range(0, 6));
         deadlines[i] = $urandom;
      end
      mode = 2'($urandom_range(0, 3));
      enter_reset(); release_reset();
      for (int c = 0; c < 3000; c++) begin
         valid    = ($urandom_range(0, 1) == 0);
         id       = 2'($urandom_range(0, 3));
         packet   = {$urandom, $urandom, $urandom, $urandom};
         consumed = ((c / 400) % 2 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
         if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
         step();
         n_vec++;
         if (activate_out !== m_act) begin n_err++; $display("FAIL rnd_act c=%0d got %b exp %b", c, activate_out, m_act); end
         for (int i = 0; i < NQ; i++) begin
            n_vec++;
            if (full[i] !== (mq[i].size() == DEPTH)) begin
               n_err++; $display("FAIL rnd_full c=%0d q=%0d got %b exp %0d", c, i, full[i], mq[i].size());
            end
`ifdef MMQS_DROP_STATS_EN
            n_vec++;
            if (drop_count[i] !== 16'(m_drop[i])) begin
               n_err++; $display("FAIL rnd_drop c=%0d q=%0d got %0d exp %0d", c, i, drop_count[i], m_drop[i]);
            end
`endif
         end
         if (m_act) begin
            n_vec++;
            if (packet_out !== m_pkt) begin n_err++; $display("FAIL rnd_pkt c=%0d got %h exp %h", c, packet_out, m_pkt); end
         end
      end
      valid = 0; consumed = 0;
   endtask

   initial begin
      reset = 1'b0; valid = 0; id = '0; packet = '0; consumed = 0; mode = 2'd2;
      for (int i = 0; i < NQ; i++) begin deadlines[i] = 32'd10; periods[i] = 32'd1; end
      test_reset();
      test_fixed_priority();
      test_full_drop();
      test_tdma();
      test_edf_order();
      test_edf_signed();
      test_reset_in_grant();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout got no finish exp finish");
      $fatal(1, "timeout");
   end

endmodule
